// File: rtl/updown_counter_p.sv
// updown_counter_p: up / down / ping-pong counter with sync clear, clamped load and terminal-count pulse.
// Optional macro UPDOWN_COUNTER_P_SAT_EN: modes 01 and 10 saturate at the bounds instead of wrapping.
module updown_counter_p #(
    parameter int unsigned      WIDTH   = 6,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             tc
);

    localparam logic [1:0]       MODE_HOLD = 2'b00;
    localparam logic [1:0]       MODE_UP   = 2'b01;
    localparam logic [1:0]       MODE_DOWN = 2'b10;
    localparam logic [1:0]       MODE_PING = 2'b11;
    localparam logic [WIDTH-1:0] ZERO      = '0;
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

`ifdef UPDOWN_COUNTER_P_SAT_EN
    localparam logic [WIDTH-1:0] UP_WRAP   = MAX_VAL;
    localparam logic [WIDTH-1:0] DOWN_WRAP = ZERO;
`else
    localparam logic [WIDTH-1:0] UP_WRAP   = ZERO;
    localparam logic [WIDTH-1:0] DOWN_WRAP = MAX_VAL;
`endif

    logic [WIDTH-1:0] r_count;
    logic             r_dir;
    logic             r_tc;
    logic             r_armed;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_dir_nxt;
    logic             w_tc_nxt;
    logic             w_step;
    logic             w_up;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_over;

    // Next count / direction / terminal-count; priority clr > load > step > hold.
    always_comb begin
        w_count_nxt = r_count;
        w_dir_nxt   = r_dir;
        w_tc_nxt    = 1'b0;
        w_step      = en && r_armed && (mode != MODE_HOLD);
        w_up        = (mode == MODE_UP) || ((mode == MODE_PING) && !r_dir);
        w_at_max    = (r_count == MAX_VAL);
        w_at_zero   = (r_count == ZERO);
        w_over      = (r_count > MAX_VAL);

        if (clr) begin
            w_count_nxt = ZERO;
            w_dir_nxt   = 1'b0;
        end else if (load) begin
            w_count_nxt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (w_step) begin
            if (mode == MODE_UP) begin
                w_dir_nxt = 1'b0;
            end else if (mode == MODE_DOWN) begin
                w_dir_nxt = 1'b1;
            end

            if (w_up) begin
                if (w_over) begin
                    w_count_nxt = ZERO;
                end else if (w_at_max) begin
                    w_tc_nxt = 1'b1;
                    if (mode == MODE_PING) begin
                        w_count_nxt = MAX_VAL - ONE;
                        w_dir_nxt   = 1'b1;
                    end else begin
                        w_count_nxt = UP_WRAP;
                    end
                end else begin
                    w_count_nxt = r_count + ONE;
                end
            end else begin
                if (w_over) begin
                    w_count_nxt = MAX_VAL;
                end else if (w_at_zero) begin
                    w_tc_nxt = 1'b1;
                    if (mode == MODE_PING) begin
                        w_count_nxt = ONE;
                        w_dir_nxt   = 1'b0;
                    end else begin
                        w_count_nxt = DOWN_WRAP;
                    end
                end else begin
                    w_count_nxt = r_count - ONE;
                end
            end
        end
    end

    // r_armed blocks stepping on the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= ZERO;
            r_dir   <= 1'b0;
            r_tc    <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_dir   <= w_dir_nxt;
            r_tc    <= w_tc_nxt;
            r_armed <= 1'b1;
        end
    end

    assign count = r_count;
    assign dir   = r_dir;
    assign tc    = r_tc;

endmodule

// File: tb/tb_updown_counter_p.sv
// tb_updown_counter_p: four counters (MAX_VAL 63, 9, 40, 1) on shared stimulus, each checked every
// cycle against an integer reference model; directed phases first, then randomized traffic.
module tb_updown_counter_p;

    localparam int unsigned W  = 6;
    localparam int unsigned NI = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic         clr = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;

    logic [W-1:0] cnt_o [NI];
    logic         dir_o [NI];
    logic         tc_o  [NI];

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model state, plain integers.
    int maxv  [NI] = '{63, 9, 40, 1};
    int m_cnt [NI];
    int m_dir [NI];
    int m_tc  [NI];
    bit m_fresh;

`ifdef UPDOWN_COUNTER_P_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    always #5 clk = ~clk;

    updown_counter_p #(.WIDTH(W)) u_dut_63 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .clr(clr), .load(load),
        .load_val(load_val), .count(cnt_o[0]), .dir(dir_o[0]), .tc(tc_o[0]));
    updown_counter_p #(.WIDTH(W), .MAX_VAL(6'd9)) u_dut_9 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .clr(clr), .load(load),
        .load_val(load_val), .count(cnt_o[1]), .dir(dir_o[1]), .tc(tc_o[1]));
    updown_counter_p #(.WIDTH(W), .MAX_VAL(6'd40)) u_dut_40 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .clr(clr), .load(load),
        .load_val(load_val), .count(cnt_o[2]), .dir(dir_o[2]), .tc(tc_o[2]));
    updown_counter_p #(.WIDTH(W), .MAX_VAL(6'd1)) u_dut_1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .clr(clr), .load(load),
        .load_val(load_val), .count(cnt_o[3]), .dir(dir_o[3]), .tc(tc_o[3]));

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_cnt[k] = 0;
            m_dir[k] = 0;
            m_tc[k]  = 0;
        end
        m_fresh = 1'b1;
    endtask

    // One rising edge of the reference: counting rules written as integer arithmetic.
    task automatic model_edge();
        if (rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < NI; k++) begin
            int  mx   = maxv[k];
            int  c    = m_cnt[k];
            int  d    = m_dir[k];
            int  t    = 0;
            int  m    = int'(mode);
            bit  goup;
            if (clr) begin
                c = 0;
                d = 0;
            end else if (load) begin
                c = (int'(load_val) > mx) ? mx : int'(load_val);
            end else if (en && !m_fresh && m != 0) begin
                if (m == 1) d = 0;
                if (m == 2) d = 1;
                goup = (d == 0);
                if (goup) begin
                    if (c > mx) c = 0;
                    else if (c == mx) begin
                        t = 1;
                        if (m == 3) begin c = mx - 1; d = 1; end
                        else c = SAT ? mx : 0;
                    end else c = c + 1;
                end else begin
                    if (c > mx) c = mx;
                    else if (c == 0) begin
                        t = 1;
                        if (m == 3) begin c = 1; d = 0; end
                        else c = SAT ? 0 : mx;
                    end else c = c - 1;
                end
            end
            m_cnt[k] = c;
            m_dir[k] = d;
            m_tc[k]  = t;
        end
        m_fresh = 1'b0;
    endtask

    task automatic compare_all(input string tag);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s.count[max%0d]", tag, maxv[k]), int'(cnt_o[k]), m_cnt[k]);
            check($sformatf("%s.dir[max%0d]", tag, maxv[k]), int'(dir_o[k]), m_dir[k]);
            check($sformatf("%s.tc[max%0d]", tag, maxv[k]), int'(tc_o[k]), m_tc[k]);
        end
    endtask

    // Inputs are set before calling; sample 1 time unit after the edge.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    // Async reset mid-cycle, checked before the next edge, held across one edge, then released.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all(tag);
        cycle({tag, "_hold"});
        rst = 1'b0;
    endtask

    task automatic run(input string tag, input int n, input logic [1:0] md);
        mode = md;
        en   = 1'b1;
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    initial begin
        model_reset();
        #23;
        compare_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Release edge must not step.
        mode = 2'b01;
        en   = 1'b1;
        cycle("first_edge");

        run("up", 70, 2'b01);
        run("down", 25, 2'b10);

        async_reset("rst_a");
        cycle("fresh");
        run("ping", 40, 2'b11);
        run("switch_up", 5, 2'b01);
        run("hold", 4, 2'b00);
        en = 1'b0;
        mode = 2'b11;
        cycle("en_low");

        load = 1'b1;
        load_val = 6'd50;
        cycle("load50");
        check("load_clamp40", int'(cnt_o[2]), 40);
        check("load_clamp9", int'(cnt_o[1]), 9);
        clr = 1'b1;
        cycle("load_clr");
        check("load_clr_zero", int'(cnt_o[0]), 0);
        clr  = 1'b0;
        load = 1'b0;

        // Run up to 17 on the 63 counter, then reset asynchronously.
        mode = 2'b01;
        en = 1'b1;
        for (int i = 0; i < 200 && m_cnt[0] != 17; i++) cycle("to17");
        check("reach17", int'(cnt_o[0]), 17);
        async_reset("rst_17");
        check("rst17_count", int'(cnt_o[0]), 0);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 11) == 0) mode = 2'($urandom_range(0, 3));
            en       = ($urandom_range(0, 7) != 0);
            clr      = ($urandom_range(0, 31) == 0);
            load     = ($urandom_range(0, 15) == 0);
            load_val = W'($urandom);
            if ($urandom_range(0, 299) == 0) async_reset("rnd_rst");
            else cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
